piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_cnt.sv | 33 +++
 rtl/piso_tx.sv | 84 ++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the piso_tx serialiser.
//   state_t / IDLE / SHIFT : FSM state encoding of the transmitter
//   DEFAULT_WIDTH          : default parallel word length
//   cnt_width()            : bit-counter width for a given word length
package piso_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt -- down-counter tracking the bits still to follow the one on q.
//   clk, reset : clock and asynchronous active-high reset
//   load       : reload to WIDTH-1 (takes priority over dec)
//   dec        : decrement by one, saturating at zero
//   cnt        : current count
//   zero       : count is zero (current bit is the final one)
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH - 1);
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in / serial-out transmitter, MSB first, with a
// valid/ready load handshake and gap-free back-to-back words.
//   clk, reset  : clock and asynchronous active-high reset
//   din         : parallel word to send
//   load_valid  : din holds a word to send
//   load_ready  : word accepted this cycle when load_valid is also high
//   q           : serial data (IDLE_LEVEL when nothing is sent)
//   q_valid     : q carries a data bit
//   last        : q carries the LSB of the word
//   busy        : a word is being shifted out
module piso_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  CW         = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            cnt_one;
  logic            xfer;

  // last is only ever high in SHIFT on the final bit, so it doubles as
  // the "can take the next word" condition while shifting.
  assign load_ready = (state == IDLE) || last;
  assign xfer       = load_valid && load_ready;
  assign cnt_one    = (cnt == CW'(1));

  // Count = number of bits still to follow the bit currently on q.
  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (xfer),
    .dec   (state == SHIFT),
    .cnt   (cnt),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      q       <= IDLE_LEVEL;
      q_valid <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end else if (xfer) begin
      // MSB goes straight to q; the register keeps the remaining bits
      // left-aligned so the next bit is always sreg[WIDTH-1].
      state   <= SHIFT;
      q       <= din[WIDTH-1];
      sreg    <= {din[WIDTH-2:0], 1'b0};
      q_valid <= 1'b1;
      last    <= 1'b0;
      busy    <= 1'b1;
    end else if ((state == SHIFT) && !cnt_zero) begin
      q    <= sreg[WIDTH-1];
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      last <= cnt_one;
    end else begin
      state   <= IDLE;
      q       <= IDLE_LEVEL;
      q_valid <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end
  end

endmodule
